// File: rtl/row_result_collector.sv
// Collects per-row dot-product results into a FIFO and delivers them downstream with row indices.
// Optional macro ROW_COLLECTOR_DROP_COUNT_EN adds a saturating dropped_count output.
module row_result_collector #(
  parameter int unsigned element_width = 32,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned PTR_W         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [15:0]              no_of_rows,
  input  logic [element_width-1:0] result,
  input  logic                     decoder_read_now,
  output logic [element_width-1:0] out_data,
  output logic [15:0]              out_row_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     all_rows_done,
  output logic                     overflow
`ifdef ROW_COLLECTOR_DROP_COUNT_EN
  ,
  output logic [15:0]              dropped_count
`endif
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [15:0]              rows_q, rows_d;
  logic [15:0]              rcv_q, rcv_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [element_width-1:0] data_q, data_d;
  logic [15:0]              idx_q, idx_d;
  logic                     valid_q, valid_d;
  logic                     ovf_q, ovf_d;
  logic                     busy_q, done_q;
`ifdef ROW_COLLECTOR_DROP_COUNT_EN
  logic [15:0]              drop_q, drop_d;
`endif

  logic                     push, pop, drop;
  logic [PTR_W-1:0]         rd_nxt;

  // Row storage keeps the strobe-order index next to each value so drops leave gaps.
  logic [element_width-1:0] mem_data [FIFO_DEPTH];
  logic [15:0]              mem_idx  [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rows_q   <= '0;
      rcv_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ROW_COLLECTOR_DROP_COUNT_EN
      drop_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      rcv_q    <= rcv_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      busy_q   <= (state_d == COLLECT) || (state_d == DRAIN);
      done_q   <= (state_d == DONE);
`ifdef ROW_COLLECTOR_DROP_COUNT_EN
      drop_q   <= drop_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= result;
      mem_idx[wr_ptr_q]  <= rcv_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    rcv_d    = rcv_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
`ifdef ROW_COLLECTOR_DROP_COUNT_EN
    drop_d   = drop_q;
`endif
    push     = 1'b0;
    drop     = 1'b0;
    pop      = valid_q && out_ready;
    rd_nxt   = rd_ptr_q + PTR_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d  = no_of_rows;
          rcv_d   = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
`ifdef ROW_COLLECTOR_DROP_COUNT_EN
          drop_d  = '0;
`endif
          state_d = (no_of_rows != 16'd0) ? COLLECT : DONE;
        end
      end
      COLLECT: begin
        if (decoder_read_now) begin
          rcv_d = rcv_q + 16'd1;
          if ((count_q != FULL_CNT) || pop) begin
            push = 1'b1;
          end else begin
            drop = 1'b1;
          end
          if (rcv_d == rows_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (count_q == '0) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_nxt;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    valid_d = (count_d != '0);

    // Head register: take the incoming row when it lands in an empty slot, else the next stored entry.
    if (pop) begin
      if (count_q == CNT_W'(1)) begin
        if (push) begin
          data_d = result;
          idx_d  = rcv_q;
        end else begin
          idx_d  = idx_q + 16'd1;
        end
      end else begin
        data_d = mem_data[rd_nxt];
        idx_d  = mem_idx[rd_nxt];
      end
    end else if (push && (count_q == '0)) begin
      data_d = result;
      idx_d  = rcv_q;
    end

    if (drop) begin
      ovf_d = 1'b1;
`ifdef ROW_COLLECTOR_DROP_COUNT_EN
      if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
`endif
    end
  end

  assign out_data      = data_q;
  assign out_row_index = idx_q;
  assign out_valid     = valid_q;
  assign busy          = busy_q;
  assign all_rows_done = done_q;
  assign overflow      = ovf_q;
`ifdef ROW_COLLECTOR_DROP_COUNT_EN
  assign dropped_count = drop_q;
`endif

endmodule

// File: tb/tb_row_result_collector.sv
// Randomized scoreboard bench for row_result_collector: driver predicts rows into a queue,
// a negedge monitor pops and compares whenever the DUT hands over a row.
module tb_row_result_collector;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset, start, decoder_read_now, out_ready;
  logic [15:0]   no_of_rows, out_row_index;
  logic [W-1:0]  result, out_data;
  logic          out_valid, busy, all_rows_done, overflow;
`ifdef ROW_COLLECTOR_DROP_COUNT_EN
  logic [15:0]   dropped_count;
`endif

  always #5 clk = ~clk;

  row_result_collector #(.element_width(W), .FIFO_DEPTH(DEPTH), .PTR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .no_of_rows(no_of_rows), .result(result),
    .decoder_read_now(decoder_read_now), .out_data(out_data), .out_row_index(out_row_index),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .all_rows_done(all_rows_done),
    .overflow(overflow)
`ifdef ROW_COLLECTOR_DROP_COUNT_EN
    , .dropped_count(dropped_count)
`endif
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic [15:0]  idx;
  } item_t;

  item_t sbq[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  // Pass-level model: 0 idle, 1 collecting rows, 2 all rows received (draining / finishing)
  int    phase = 0;
  int    m_rows = 0;
  int    rcv = 0;
  bit    exp_ovf = 1'b0;
  int    exp_drops = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, predict their effect from the queue occupancy, commit after the edge.
  task automatic step(input logic st, input logic [15:0] rows, input logic strb,
                      input logic [W-1:0] res, input logic rdy, input logic rst);
    bit    pop_p, push_p, drop_p, start_p;
    item_t it;
    reset = rst; start = st; no_of_rows = rows; decoder_read_now = strb;
    result = res; out_ready = rdy;
    pop_p = rdy && (sbq.size() != 0);
    push_p = 1'b0; drop_p = 1'b0; start_p = 1'b0;
    it = '0;
    if (!rst) begin
      if (st && phase == 0) begin
        start_p = 1'b1;
        m_rows = int'(rows);
        rcv = 0;
        phase = (rows != 16'd0) ? 1 : 2;
      end else if (strb && phase == 1) begin
        it.data = res;
        it.idx  = 16'(rcv);
        rcv++;
        if (sbq.size() < DEPTH || pop_p) push_p = 1'b1;
        else drop_p = 1'b1;
        if (rcv == m_rows) phase = 2;
      end
    end
    @(posedge clk);
    if (rst) begin
      sbq.delete();
      phase = 0; exp_ovf = 1'b0; exp_drops = 0;
    end else begin
      if (start_p) begin exp_ovf = 1'b0; exp_drops = 0; end
      if (push_p) sbq.push_back(it);
      if (drop_p) begin exp_ovf = 1'b1; exp_drops++; end
    end
    #1;
  endtask

  task automatic collect(input int strb_pct, input int rdy_pct);
    for (int i = 0; i < 3000 && phase == 1; i++)
      step($urandom_range(0, 19) == 0, 16'($urandom_range(0, 40)),
           $urandom_range(0, 99) < strb_pct, $urandom, $urandom_range(0, 99) < rdy_pct, 1'b0);
    check(phase != 1, "collect_timeout", rcv, m_rows);
  endtask

  task automatic finish_pass(input int rdy_pct);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (all_rows_done) seen = 1'b1;
      else step($urandom_range(0, 9) == 0, 16'($urandom_range(0, 30)), $urandom_range(0, 1) == 1,
                $urandom, $urandom_range(0, 99) < rdy_pct, 1'b0);
    end
    check(seen, "done_seen", seen, 1);
    check(sbq.size() == 0, "done_with_rows_pending", sbq.size(), 0);
    step(1'b0, 16'd0, 1'b0, '0, 1'b1, 1'b0);
    check(!all_rows_done && !busy, "done_single_cycle", {all_rows_done, busy}, 0);
    phase = 0;
  endtask

  always @(negedge clk) begin : monitor
    item_t e;
    if (mon_en) begin
      check(out_valid == (sbq.size() != 0), "out_valid", out_valid, sbq.size() != 0);
      check(overflow == exp_ovf, "overflow", overflow, exp_ovf);
      if (all_rows_done)
        check(phase == 2 && sbq.size() == 0, "early_done", sbq.size(), 0);
      if (out_valid && out_ready && sbq.size() != 0) begin
        e = sbq.pop_front();
        check(out_data == e.data, "out_data", out_data, e.data);
        check(out_row_index == e.idx, "out_row_index", out_row_index, e.idx);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; no_of_rows = '0; decoder_read_now = 1'b0;
    result = '0; out_ready = 1'b0;
    #1;
    step(1'b0, 16'd0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b0, '0, 1'b0, 1'b1);
    mon_en = 1'b1;
    check({out_valid, busy, all_rows_done, overflow} == 4'b0, "reset_flags",
          {out_valid, busy, all_rows_done, overflow}, 0);
    check(out_data == '0 && out_row_index == 16'd0, "reset_data", out_data, 0);

    // Three rows with ready held high
    step(1'b1, 16'd3, 1'b0, '0, 1'b1, 1'b0);
    check(busy == 1'b1, "busy_after_start", busy, 1);
    step(1'b0, 16'd0, 1'b1, 32'h3F80_0000, 1'b1, 1'b0);
    step(1'b0, 16'd0, 1'b1, 32'h4000_0000, 1'b1, 1'b0);
    step(1'b0, 16'd0, 1'b1, 32'h4040_0000, 1'b1, 1'b0);
    finish_pass(100);

    // Zero-row pass: done right after start, nothing delivered
    step(1'b1, 16'd0, 1'b0, '0, 1'b1, 1'b0);
    check(all_rows_done == 1'b1, "zero_rows_done", all_rows_done, 1);
    finish_pass(100);

    // Twenty rows into a stalled sink: four drops
    step(1'b1, 16'd20, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 16'd0, 1'b1, $urandom, 1'b0, 1'b0);
    check(overflow == 1'b1, "overflow_after_20", overflow, 1);
`ifdef ROW_COLLECTOR_DROP_COUNT_EN
    check(dropped_count == 16'd4, "dropped_count", dropped_count, 4);
`endif
    finish_pass(100);

    // Full buffer, strobe and pop together: nothing dropped
    step(1'b1, 16'd17, 1'b0, '0, 1'b0, 1'b0);
    check(overflow == 1'b0, "overflow_cleared_by_start", overflow, 0);
    for (int i = 0; i < 16; i++) step(1'b0, 16'd0, 1'b1, $urandom, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, $urandom, 1'b1, 1'b0);
    step(1'b0, 16'd0, 1'b0, '0, 1'b0, 1'b0);
    check(overflow == 1'b0, "full_push_pop_no_overflow", overflow, 0);
    finish_pass(100);

    // Reset mid-pass, then a one-row pass
    step(1'b1, 16'd5, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b0, '0, 1'b0, 1'b1);
    check(!out_valid && !busy && !all_rows_done, "midpass_reset_flags",
          {out_valid, busy, all_rows_done}, 0);
    check(out_data == '0 && out_row_index == 16'd0, "midpass_reset_data", out_data, 0);
    step(1'b1, 16'd1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 16'd0, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
    finish_pass(100);

    // Strobe in IDLE and restart during COLLECT are ignored
    step(1'b0, 16'd0, 1'b1, 32'hBAD0_0001, 1'b1, 1'b0);
    check(busy == 1'b0, "idle_strobe_busy", busy, 0);
    step(1'b1, 16'd2, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 16'd9, 1'b1, 32'h0000_00A1, 1'b1, 1'b0);
    step(1'b0, 16'd0, 1'b1, 32'h0000_00A2, 1'b1, 1'b0);
    finish_pass(100);

    // Randomized passes
    for (int p = 0; p < 30; p++) begin
      step(1'b1, ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 24)),
           1'b0, '0, $urandom_range(0, 1) == 1, 1'b0);
      collect($urandom_range(40, 100), $urandom_range(0, 100));
      finish_pass($urandom_range(30, 100));
    end

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
